char_display_scanner: RTL and testbench

//  Read side of the character-mode VRAM: generates 640x480@60 VGA timing and scans the
//  128x32-cell VRAM through its read port and the 8x16 character ROM.

---
 rtl/char_display_scanner.sv | 193 +++++++++++++++++++
 tb/tb_char_display_scanner.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/char_display_scanner.sv
// Character-mode VGA scanner: generates display timing, walks the 128x32 text VRAM and
// the 8x16 glyph ROM, and produces RGB444 pixels with row scroll and a blinking cursor.
module char_display_scanner #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter bit SYNC_POL     = 1'b0,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [11:0] vram_addr,
    input  logic [31:0] vram_data,
    output logic [7:0]  rom_ascii,
    output logic [2:0]  rom_x,
    output logic [3:0]  rom_y,
    input  logic        rom_dot,
    input  logic [4:0]  scroll_row,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FCW-1:0] FC_LAST = FCW'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic       vis;
        logic       hs;
        logic       vs;
        logic [2:0] x;
        logic [3:0] y;
        logic [6:0] col;
        logic [4:0] row;
    } s1_t;

    typedef struct packed {
        logic        vis;
        logic        hs;
        logic        vs;
        logic [3:0]  y;
        logic [6:0]  col;
        logic [4:0]  row;
        logic [11:0] fg;
        logic [11:0] bg;
    } s2_t;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } out_t;

    logic [9:0]     hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [4:0]     scroll_q, scroll_d;
    logic           cur_en_q, cur_en_d;
    logic [6:0]     cur_col_q, cur_col_d;
    logic [4:0]     cur_row_q, cur_row_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic           blink_q, blink_d;
    s1_t            s1_q, s1_d;
    s2_t            s2_q, s2_d;
    out_t           out_q, out_d;
    logic [4:0]     fetch_row;
    logic           frame_end;
    logic           cursor_hit;
    logic [11:0]    colour;

    // Raster counters; per-frame settings are only taken on the last pixel of a frame.
    always_comb begin
        hcnt_d      = hcnt_q + 10'd1;
        vcnt_d      = vcnt_q;
        scroll_d    = scroll_q;
        cur_en_d    = cur_en_q;
        cur_col_d   = cur_col_q;
        cur_row_d   = cur_row_q;
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        frame_end   = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
        end
        if (frame_end) begin
            scroll_d  = scroll_row;
            cur_en_d  = cursor_en;
            cur_col_d = cursor_col;
            cur_row_d = cursor_row;
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // The address depends only on flops, so a synchronous VRAM returns the word next cycle.
    always_comb begin
        fetch_row = vcnt_q[8:4] + scroll_q;
        vram_addr = {fetch_row, hcnt_q[9:3]};
        s1_d.vis  = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
        s1_d.hs   = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
        s1_d.vs   = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
        s1_d.x    = hcnt_q[2:0];
        s1_d.y    = vcnt_q[3:0];
        s1_d.col  = hcnt_q[9:3];
        s1_d.row  = fetch_row;
    end

    assign rom_ascii = vram_data[7:0];
    assign rom_x     = s1_q.x;
    assign rom_y     = s1_q.y;

    always_comb begin
        s2_d.vis = s1_q.vis;
        s2_d.hs  = s1_q.hs;
        s2_d.vs  = s1_q.vs;
        s2_d.y   = s1_q.y;
        s2_d.col = s1_q.col;
        s2_d.row = s1_q.row;
        s2_d.fg  = vram_data[19:8];
        s2_d.bg  = vram_data[31:20];
    end

    // Cursor compares in VRAM coordinates, so it follows its text when the screen scrolls.
    always_comb begin
        cursor_hit = cur_en_q && blink_q && (s2_q.col == cur_col_q)
                     && (s2_q.row == cur_row_q) && (s2_q.y >= 4'd14);
        colour     = (rom_dot || cursor_hit) ? s2_q.fg : s2_q.bg;
        out_d.de   = s2_q.vis;
        out_d.hs   = s2_q.hs ? SYNC_POL : ~SYNC_POL;
        out_d.vs   = s2_q.vs ? SYNC_POL : ~SYNC_POL;
        out_d.rgb  = s2_q.vis ? colour : 12'h000;
    end

    // Reset loads the cursor so it is live from the first frame; scroll starts at row 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            scroll_q    <= '0;
            cur_en_q    <= cursor_en;
            cur_col_q   <= cursor_col;
            cur_row_q   <= cursor_row;
            frame_cnt_q <= '0;
            blink_q     <= 1'b1;
            s1_q        <= '0;
            s2_q        <= '0;
            out_q       <= '{de: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL, rgb: 12'h000};
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            scroll_q    <= scroll_d;
            cur_en_q    <= cur_en_d;
            cur_col_q   <= cur_col_d;
            cur_row_q   <= cur_row_d;
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            out_q       <= out_d;
        end
    end

    assign vga_de = out_q.de;
    assign vga_hs = out_q.hs;
    assign vga_vs = out_q.vs;
    assign vga_r  = out_q.rgb[11:8];
    assign vga_g  = out_q.rgb[7:4];
    assign vga_b  = out_q.rgb[3:0];
endmodule

// File: tb/tb_char_display_scanner.sv
// Bench for char_display_scanner on a shrunken raster (64x55 clocks per frame) so that
// several frames fit in a short run; VRAM and glyph ROM are behavioural models here.
module tb_char_display_scanner;
    localparam int HA = 48, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;
    localparam int VA = 48, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int BF = 2;
    localparam int MAXF = 32;
    localparam int CUR_PIX = 46 * HT + 40 + 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] vram_addr;
    logic [31:0] vram_data;
    logic [7:0]  rom_ascii;
    logic [2:0]  rom_x;
    logic [3:0]  rom_y;
    logic        rom_dot;
    logic [4:0]  scroll_row;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        vga_hs, vga_vs, vga_de;
    logic [3:0]  vga_r, vga_g, vga_b;

    logic [31:0] vram [0:4095];
    int          n_checks = 0;
    int          n_fail = 0;
    int          tcyc = 0;
    bit          model_on = 1'b0;
    int          mcyc = 0;
    int          fr_scroll [0:MAXF-1];
    bit          fr_cen    [0:MAXF-1];
    int          fr_ccol   [0:MAXF-1];
    int          fr_crow   [0:MAXF-1];

    char_display_scanner #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .vram_addr(vram_addr), .vram_data(vram_data),
        .rom_ascii(rom_ascii), .rom_x(rom_x), .rom_y(rom_y), .rom_dot(rom_dot),
        .scroll_row(scroll_row), .cursor_en(cursor_en),
        .cursor_col(cursor_col), .cursor_row(cursor_row),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #5 clk = ~clk;

    // Glyph ROM contents: space is blank, other codes get an arbitrary but fixed pattern.
    function automatic logic glyph(input logic [7:0] a, input int y, input int x);
        logic [7:0] s;
        if (a == 8'h20) return 1'b0;
        s = a >> (x % 3);
        return s[0] ^ y[0] ^ x[0];
    endfunction

    // Synchronous VRAM and ROM: each answers one clock after its address.
    always @(posedge clk) vram_data <= vram[vram_addr];
    always @(posedge clk) rom_dot <= glyph(rom_ascii, int'(rom_y), int'(rom_x));

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Expected outputs for cycle c after reset release: pixel c-3 on the pins, pixel c fetched.
    task automatic model_cycle(input int c);
        int p, fk, h, v, row, col, exp_rgb;
        logic [31:0] w;
        bit exp_de, exp_hs, exp_vs, dot, hit;
        exp_de = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1; exp_rgb = 0;
        if (c >= 3) begin
            p  = c - 3;
            fk = (p / FT < MAXF) ? p / FT : MAXF - 1;
            h  = (p % FT) % HT;
            v  = (p % FT) / HT;
            exp_hs = !(h >= HA + HF && h < HA + HF + HS);
            exp_vs = !(v >= VA + VF && v < VA + VF + VS);
            exp_de = (h < HA) && (v < VA);
            if (exp_de) begin
                row = (v / 16 + fr_scroll[fk]) % 32;
                col = h / 8;
                w   = vram[row * 128 + col];
                dot = glyph(w[7:0], v % 16, h % 8);
                hit = fr_cen[fk] && ((fk / BF) % 2 == 0) && col == fr_ccol[fk]
                      && row == fr_crow[fk] && (v % 16) >= 14;
                exp_rgb = dot || hit ? int'(w[19:8]) : int'(w[31:20]);
            end
        end
        check_output("model_de", 32'(vga_de), 32'(exp_de));
        check_output("model_hs", 32'(vga_hs), 32'(exp_hs));
        check_output("model_vs", 32'(vga_vs), 32'(exp_vs));
        check_output("model_rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
        fk = (c / FT < MAXF) ? c / FT : MAXF - 1;
        h  = (c % FT) % HT;
        v  = (c % FT) / HT;
        if (h < HA && v < VA) begin
            row = (v / 16 + fr_scroll[fk]) % 32;
            check_output("model_addr", 32'(vram_addr), 32'(row * 128 + h / 8));
        end
    endtask

    // Compare process: settings of frame k are the inputs present on the last clock of frame k-1.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_on     = 1'b1;
            mcyc         = 0;
            fr_scroll[0] = 0;
            fr_cen[0]    = cursor_en;
            fr_ccol[0]   = int'(cursor_col);
            fr_crow[0]   = int'(cursor_row);
        end else if (model_on) begin
            model_cycle(mcyc);
            if ((mcyc + 1) % FT == 0 && (mcyc + 1) / FT < MAXF) begin
                fr_scroll[(mcyc + 1) / FT] = int'(scroll_row);
                fr_cen[(mcyc + 1) / FT]    = cursor_en;
                fr_ccol[(mcyc + 1) / FT]   = int'(cursor_col);
                fr_crow[(mcyc + 1) / FT]   = int'(cursor_row);
            end
            mcyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        tcyc++;
    endtask

    task automatic goto_cycle(input int n);
        while (tcyc < n) step();
    endtask

    task automatic apply_stimulus_reset(input int n);
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst_n = 1'b1;
        tcyc = 0;
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_hs"}, 32'(vga_hs), 32'd1);
        check_output({tag, "_vs"}, 32'(vga_vs), 32'd1);
        check_output({tag, "_de"}, 32'(vga_de), 32'd0);
        check_output({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'h000);
        check_output({tag, "_addr"}, 32'(vram_addr), 32'h000);
    endtask

    // Directed sequence: reset, one full frame of timing, cursor blink, scroll, mid-line reset.
    initial begin
        int de_cnt, hs_cnt, vs_cnt;
        rst_n = 1'b0; scroll_row = 5'd0;
        cursor_en = 1'b1; cursor_col = 7'd5; cursor_row = 5'd2;
        for (int a = 0; a < 4096; a++)
            vram[a] = {12'(a * 37 + 5), 12'(a * 91 + 2748), 8'(a * 13 + 7)};
        vram[0]           = 32'h000FFF41;
        vram[1]           = 32'h000FFF40;
        vram[2 * 128 + 5] = 32'h00FF0020;

        apply_stimulus_reset(10);
        check_reset_state("reset");

        de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        for (int c = 1; c <= FT + 2; c++) begin
            step();
            if (c >= 3) begin
                de_cnt += int'(vga_de);
                hs_cnt += int'(!vga_hs);
                vs_cnt += int'(!vga_vs);
            end
            if (c == 2) check_output("pix_de_before", 32'(vga_de), 32'd0);
            if (c == 3) begin
                check_output("pix00_de", 32'(vga_de), 32'd1);
                check_output("pix00_rgb", 32'({vga_r, vga_g, vga_b}), 32'hFFF);
            end
            if (c == 11) begin
                check_output("pix80_de", 32'(vga_de), 32'd1);
                check_output("pix80_rgb", 32'({vga_r, vga_g, vga_b}), 32'h000);
            end
            if (c == CUR_PIX - HT) check_output("cursor_y13_f0", 32'({vga_r, vga_g, vga_b}), 32'h00F);
            if (c == CUR_PIX) check_output("cursor_f0", 32'({vga_r, vga_g, vga_b}), 32'hF00);
            if (c == 50 * HT + 2) check_output("vs_before_f0", 32'(vga_vs), 32'd1);
            if (c == 50 * HT + 3) check_output("vs_start_f0", 32'(vga_vs), 32'd0);
        end
        check_output("de_per_frame", 32'(de_cnt), 32'(HA * VA));
        check_output("hs_low_per_frame", 32'(hs_cnt), 32'(HS * VT));
        check_output("vs_low_per_frame", 32'(vs_cnt), 32'(VS * HT));

        goto_cycle(FT + CUR_PIX);
        check_output("cursor_f1", 32'({vga_r, vga_g, vga_b}), 32'hF00);
        goto_cycle(FT + 50 * HT + 2);
        check_output("vs_before_f1", 32'(vga_vs), 32'd1);
        step();
        check_output("vs_start_f1", 32'(vga_vs), 32'd0);
        goto_cycle(2 * FT + CUR_PIX);
        check_output("cursor_f2", 32'({vga_r, vga_g, vga_b}), 32'h00F);
        goto_cycle(3 * FT + CUR_PIX);
        check_output("cursor_f3", 32'({vga_r, vga_g, vga_b}), 32'h00F);
        goto_cycle(4 * FT + CUR_PIX);
        check_output("cursor_f4", 32'({vga_r, vga_g, vga_b}), 32'hF00);

        goto_cycle(4 * FT + 3020);
        scroll_row = 5'd31;
        goto_cycle(5 * FT);
        check_output("scroll_row0_addr", 32'(vram_addr), 32'hF80);
        goto_cycle(5 * FT + 8);
        check_output("scroll_row0_col1", 32'(vram_addr), 32'hF81);
        goto_cycle(5 * FT + 16 * HT);
        check_output("scroll_row1_addr", 32'(vram_addr), 32'h000);
        goto_cycle(5 * FT + 20 * HT);
        scroll_row = 5'd3;
        goto_cycle(5 * FT + 32 * HT);
        check_output("scroll_midframe_hold", 32'(vram_addr), 32'h080);
        goto_cycle(6 * FT);
        check_output("scroll_next_frame", 32'(vram_addr), 32'h180);
        goto_cycle(6 * FT + 16 * HT + 16);
        check_output("scroll_row1_col2", 32'(vram_addr), 32'h202);

        goto_cycle(6 * FT + 20 * HT + 30);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tcyc = 0;
        #1;
        check_reset_state("midreset");
        goto_cycle(2);
        check_output("midreset_de_c2", 32'(vga_de), 32'd0);
        goto_cycle(3);
        check_output("midreset_de_c3", 32'(vga_de), 32'd1);
        check_output("midreset_rgb_c3", 32'({vga_r, vga_g, vga_b}), 32'hFFF);
        goto_cycle(700);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
